// File: rtl/bit_serial_addsub_ctrl_if.sv
// Request/response bundle between a controller and the bit-serial add/sub sequencer.
interface bit_serial_addsub_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  modport master (
    output start, op, a, b,
    input  busy, done, result, carry_out, overflow
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, carry_out, overflow
  );
endinterface

// File: rtl/bit_serial_addsub_ctrl.sv
// Bit-serial WIDTH-bit adder/subtractor: one shared 1-bit cell, LSB first,
// carry/borrow held in a flop between bits.
module bit_serial_addsub_cell (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic sub,
  output logic s,
  output logic c_next
);
  always_comb begin
    s = a ^ b ^ c;
    if (sub) c_next = (~a & b) | (~(a ^ b) & c);
    else     c_next = (a & b) | (a & c) | (b & c);
  end
endmodule

module bit_serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  bit_serial_addsub_ctrl_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] result_q;
  logic [CW-1:0]    cnt;
  logic             op_q;
  logic             c_q;
  logic             busy_q;
  logic             done_q;
  logic             carry_q;
  logic             ovf_q;
  logic             sum;
  logic             c_nxt;
  logic             last;
  logic             ovf_nxt;
  logic [WIDTH-1:0] result_shift;

  bit_serial_addsub_cell u_cell (
    .a      (a_sh[0]),
    .b      (b_sh[0]),
    .c      (c_q),
    .sub    (op_q),
    .s      (sum),
    .c_next (c_nxt)
  );

  // On the last bit, bit 0 of the operand shifters holds the original MSBs.
  always_comb begin
    last         = (cnt == CW'(WIDTH - 1));
    result_shift = WIDTH'({sum, result_q} >> 1);
    if (op_q) ovf_nxt = (a_sh[0] != b_sh[0]) && (sum != a_sh[0]);
    else      ovf_nxt = (a_sh[0] == b_sh[0]) && (sum != a_sh[0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      result_q <= '0;
      cnt      <= '0;
      op_q     <= 1'b0;
      c_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          a_sh     <= a_sh >> 1;
          b_sh     <= b_sh >> 1;
          c_q      <= c_nxt;
          result_q <= result_shift;
          cnt      <= cnt + 1'b1;
          if (last) begin
            carry_q <= c_nxt;
            ovf_q   <= ovf_nxt;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state   <= DONE;
          end
        end
        default: begin
          // IDLE and DONE both accept; done always drops after one cycle.
          done_q <= 1'b0;
          if (bus.start) begin
            a_sh   <= bus.a;
            b_sh   <= bus.b;
            op_q   <= bus.op;
            c_q    <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.carry_out = carry_q;
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_bit_serial_addsub_ctrl.sv
// Directed self-checking bench for bit_serial_addsub_ctrl at WIDTH=8 and WIDTH=1.
module tb_bit_serial_addsub_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  bit_serial_addsub_ctrl_if #(.WIDTH(8)) bus8 ();
  bit_serial_addsub_ctrl_if #(.WIDTH(1)) bus1 ();

  bit_serial_addsub_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
  bit_serial_addsub_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called right after the accept edge's negedge; returns cycles until done, -1 on timeout.
  task automatic wait_done8(output int lat);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus8.done) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic op8(input string tag, input logic op, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] er, input logic ec, input logic ev);
    int lat;
    bus8.start = 1'b1; bus8.op = op; bus8.a = a; bus8.b = b;
    @(negedge clk);
    bus8.start = 1'b0; bus8.a = ~a; bus8.b = ~b; bus8.op = ~op;
    check({tag, "_busy"}, 32'(bus8.busy), 32'd1);
    wait_done8(lat);
    check({tag, "_lat"}, 32'(lat), 32'd8);
    check({tag, "_res"}, 32'(bus8.result), 32'(er));
    check({tag, "_cout"}, 32'(bus8.carry_out), 32'(ec));
    check({tag, "_ovf"}, 32'(bus8.overflow), 32'(ev));
    @(negedge clk);
    check({tag, "_donelow"}, 32'(bus8.done), 32'd0);
  endtask

  initial begin
    int lat;
    int done_seen;
    rst_n = 1'b0;
    bus8.start = 1'b0; bus8.op = 1'b1; bus8.a = 8'hA5; bus8.b = 8'h5A;
    bus1.start = 1'b0; bus1.op = 1'b1; bus1.a = 1'b1; bus1.b = 1'b1;
    #1;
    check("rst_busy", 32'(bus8.busy), 32'd0);
    check("rst_done", 32'(bus8.done), 32'd0);
    check("rst_res", 32'(bus8.result), 32'd0);
    check("rst_cout", 32'(bus8.carry_out), 32'd0);
    check("rst_ovf", 32'(bus8.overflow), 32'd0);
    check("rst1_res", 32'({bus1.busy, bus1.done, bus1.result, bus1.carry_out, bus1.overflow}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    op8("add_3c_05", 1'b0, 8'h3C, 8'h05, 8'h41, 1'b0, 1'b0);
    op8("sub_05_07", 1'b1, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0);
    op8("sub_80_01", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    op8("add_7f_01", 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    op8("add_ff_01", 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);

    // Start during RUN is ignored; start during DONE is accepted back-to-back.
    bus8.start = 1'b1; bus8.op = 1'b0; bus8.a = 8'h12; bus8.b = 8'h34;
    @(negedge clk);
    bus8.start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin
        bus8.start = 1'b1; bus8.op = 1'b1; bus8.a = 8'hFF; bus8.b = 8'hFF;
      end
      @(negedge clk);
      bus8.start = 1'b0;
      if (bus8.done) begin
        lat = i;
        break;
      end
    end
    check("ign_lat", 32'(lat), 32'd8);
    check("ign_res", 32'(bus8.result), 32'h46);
    check("ign_cout", 32'(bus8.carry_out), 32'd0);
    bus8.start = 1'b1; bus8.op = 1'b1; bus8.a = 8'h10; bus8.b = 8'h01;
    @(negedge clk);
    bus8.start = 1'b0;
    check("b2b_donelow", 32'(bus8.done), 32'd0);
    check("b2b_busy", 32'(bus8.busy), 32'd1);
    wait_done8(lat);
    check("b2b_lat", 32'(lat), 32'd8);
    check("b2b_res", 32'(bus8.result), 32'h0F);
    check("b2b_cout", 32'(bus8.carry_out), 32'd0);
    check("b2b_ovf", 32'(bus8.overflow), 32'd0);
    @(negedge clk);

    // Asynchronous reset in the middle of a RUN.
    bus8.start = 1'b1; bus8.op = 1'b0; bus8.a = 8'h3C; bus8.b = 8'h05;
    @(negedge clk);
    bus8.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(bus8.busy), 32'd0);
    check("arst_res", 32'(bus8.result), 32'd0);
    check("arst_flags", 32'({bus8.done, bus8.carry_out, bus8.overflow}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    done_seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus8.done || bus8.busy) done_seen++;
    end
    check("arst_nodone", 32'(done_seen), 32'd0);
    op8("post_rst", 1'b1, 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);

    // WIDTH=1: all op/a/b combinations.
    for (int k = 0; k < 8; k++) begin
      logic op, a, b, er, ec, ev;
      logic [2:0] kv;
      kv = 3'(k);
      op = kv[2]; a = kv[1]; b = kv[0];
      er = a ^ b;
      ec = op ? (~a & b) : (a & b);
      ev = op ? ((a != b) && (er != a)) : ((a == b) && (er != a));
      bus1.start = 1'b1; bus1.op = op; bus1.a = a; bus1.b = b;
      @(negedge clk);
      bus1.start = 1'b0; bus1.a = ~a; bus1.b = ~b; bus1.op = ~op;
      check($sformatf("w1_%0d_busy", k), 32'(bus1.busy), 32'd1);
      @(negedge clk);
      check($sformatf("w1_%0d_done", k), 32'(bus1.done), 32'd1);
      check($sformatf("w1_%0d_out", k), 32'({bus1.result, bus1.carry_out, bus1.overflow}),
            32'({er, ec, ev}));
      @(negedge clk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
